// File: rtl/nasti_lite_mem_writer.sv
// NASTI-lite write slave: pairs AW/W beats into req/gnt memory word writes, returns in-order B.
// Latency 3 cycles handshake->B (2 for SLVERR/no-strobe); AW/W ready drop when their FIFO is full.
module nasti_lite_mem_writer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign head_dat = mem_q[rd_ptr_q];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

module nasti_lite_mem_writer #(
    parameter int          ID_WIDTH   = 1,
    parameter int          ADDR_WIDTH = 8,
    parameter int          DATA_WIDTH = 32,
    parameter int          USER_WIDTH = 1,
    parameter int          FIFO_DEPTH = 2,
    parameter int unsigned ADDR_LIMIT = 2**ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     lite_aw_id,
    input  logic [ADDR_WIDTH-1:0]   lite_aw_addr,
    input  logic [2:0]              lite_aw_prot,
    input  logic [3:0]              lite_aw_qos,
    input  logic [3:0]              lite_aw_region,
    input  logic [USER_WIDTH-1:0]   lite_aw_user,
    input  logic                    lite_aw_valid,
    output logic                    lite_aw_ready,
    input  logic [DATA_WIDTH-1:0]   lite_w_data,
    input  logic [DATA_WIDTH/8-1:0] lite_w_strb,
    input  logic [USER_WIDTH-1:0]   lite_w_user,
    input  logic                    lite_w_valid,
    output logic                    lite_w_ready,
    output logic [ID_WIDTH-1:0]     lite_b_id,
    output logic [1:0]              lite_b_resp,
    output logic [USER_WIDTH-1:0]   lite_b_user,
    output logic                    lite_b_valid,
    input  logic                    lite_b_ready,
    output logic                    mem_req,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic                    mem_gnt
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int AW_W   = ID_WIDTH + ADDR_WIDTH + USER_WIDTH;
    localparam int W_W    = DATA_WIDTH + STRB_W;
    localparam int B_W    = ID_WIDTH + 2 + USER_WIDTH;
    localparam logic [ADDR_WIDTH:0] ADDR_LIM = ADDR_LIMIT[ADDR_WIDTH:0];
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
        $fatal(1, "nasti_lite_mem_writer: DATA_WIDTH must be 32 or 64");
    end
    if (USER_WIDTH < 1) begin : g_bad_user_width
        $fatal(1, "nasti_lite_mem_writer: USER_WIDTH must be > 0");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "nasti_lite_mem_writer: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic {S_IDLE, S_REQ} state_t;

    logic                  unused_inputs;
    logic [AW_W-1:0]       aw_head;
    logic [W_W-1:0]        w_head;
    logic [B_W-1:0]        b_head, b_push_dat;
    logic                  aw_full, aw_empty, w_full, w_empty, b_full, b_empty;
    logic                  aw_pop, w_pop, b_push;
    logic [ID_WIDTH-1:0]   aw_id;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [USER_WIDTH-1:0] aw_user;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]     w_strb;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   iss_id_q, iss_id_d;
    logic [USER_WIDTH-1:0] iss_user_q, iss_user_d;
    logic [ADDR_WIDTH-1:0] iss_addr_q, iss_addr_d;
    logic [DATA_WIDTH-1:0] iss_data_q, iss_data_d;
    logic [STRB_W-1:0]     iss_be_q, iss_be_d;

    assign unused_inputs = ^{lite_aw_prot, lite_aw_qos, lite_aw_region, lite_w_user};

    nasti_lite_mem_writer_fifo #(.WIDTH(AW_W), .DEPTH(FIFO_DEPTH)) u_aw_fifo (
        .clk(clk), .rst(rst),
        .push(lite_aw_valid && lite_aw_ready),
        .push_dat({lite_aw_id, lite_aw_addr, lite_aw_user}),
        .pop(aw_pop), .head_dat(aw_head), .full(aw_full), .empty(aw_empty)
    );

    nasti_lite_mem_writer_fifo #(.WIDTH(W_W), .DEPTH(FIFO_DEPTH)) u_w_fifo (
        .clk(clk), .rst(rst),
        .push(lite_w_valid && lite_w_ready),
        .push_dat({lite_w_data, lite_w_strb}),
        .pop(w_pop), .head_dat(w_head), .full(w_full), .empty(w_empty)
    );

    nasti_lite_mem_writer_fifo #(.WIDTH(B_W), .DEPTH(FIFO_DEPTH)) u_b_fifo (
        .clk(clk), .rst(rst),
        .push(b_push), .push_dat(b_push_dat),
        .pop(lite_b_valid && lite_b_ready), .head_dat(b_head), .full(b_full), .empty(b_empty)
    );

    assign lite_aw_ready = !aw_full;
    assign lite_w_ready  = !w_full;
    assign lite_b_valid  = !b_empty;
    assign {aw_id, aw_addr, aw_user}             = aw_head;
    assign {w_data, w_strb}                      = w_head;
    assign {lite_b_id, lite_b_resp, lite_b_user} = b_head;

    assign mem_req   = (state_q == S_REQ);
    assign mem_addr  = iss_addr_q;
    assign mem_wdata = iss_data_q;
    assign mem_be    = iss_be_q;

    always_comb begin
        state_d    = state_q;
        iss_id_d   = iss_id_q;
        iss_user_d = iss_user_q;
        iss_addr_d = iss_addr_q;
        iss_data_d = iss_data_q;
        iss_be_d   = iss_be_q;
        aw_pop     = 1'b0;
        w_pop      = 1'b0;
        b_push     = 1'b0;
        b_push_dat = {iss_id_q, RESP_OKAY, iss_user_q};
        case (state_q)
            S_IDLE: begin
                if (!aw_empty && !w_empty && !b_full) begin
                    aw_pop = 1'b1;
                    w_pop  = 1'b1;
                    if ({1'b0, aw_addr} >= ADDR_LIM) begin
                        b_push     = 1'b1;
                        b_push_dat = {aw_id, RESP_SLVERR, aw_user};
                    end else if (w_strb == '0) begin
                        b_push     = 1'b1;
                        b_push_dat = {aw_id, RESP_OKAY, aw_user};
                    end else begin
                        iss_id_d   = aw_id;
                        iss_user_d = aw_user;
                        iss_addr_d = {aw_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                        iss_data_d = w_data;
                        iss_be_d   = w_strb;
                        state_d    = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // B cannot be full here: it had room on entry and only drains meanwhile.
                if (mem_gnt) begin
                    b_push  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            iss_id_q   <= '0;
            iss_user_q <= '0;
            iss_addr_q <= '0;
            iss_data_q <= '0;
            iss_be_q   <= '0;
        end else begin
            state_q    <= state_d;
            iss_id_q   <= iss_id_d;
            iss_user_q <= iss_user_d;
            iss_addr_q <= iss_addr_d;
            iss_data_q <= iss_data_d;
            iss_be_q   <= iss_be_d;
        end
    end
endmodule

// File: tb/tb_nasti_lite_mem_writer.sv
// Bench for nasti_lite_mem_writer: directed latency/edge scenarios plus randomized traffic vs a queue model.
module tb_nasti_lite_mem_writer;
    localparam int IDW = 4, AW = 8, DW = 32, UW = 2, DEPTH = 2, LIMIT = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [IDW-1:0] lite_aw_id = '0;
    logic [AW-1:0]  lite_aw_addr = '0;
    logic [2:0]     lite_aw_prot = '0;
    logic [3:0]     lite_aw_qos = '0, lite_aw_region = '0;
    logic [UW-1:0]  lite_aw_user = '0;
    logic           lite_aw_valid = 1'b0, lite_aw_ready;
    logic [DW-1:0]  lite_w_data = '0;
    logic [3:0]     lite_w_strb = '0;
    logic [UW-1:0]  lite_w_user = '0;
    logic           lite_w_valid = 1'b0, lite_w_ready;
    logic [IDW-1:0] lite_b_id;
    logic [1:0]     lite_b_resp;
    logic [UW-1:0]  lite_b_user;
    logic           lite_b_valid;
    logic           lite_b_ready = 1'b0;
    logic           mem_req;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [3:0]     mem_be;
    logic           mem_gnt = 1'b0;

    always #5 clk = ~clk;

    nasti_lite_mem_writer #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW),
                            .FIFO_DEPTH(DEPTH), .ADDR_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .lite_aw_id(lite_aw_id), .lite_aw_addr(lite_aw_addr), .lite_aw_prot(lite_aw_prot),
        .lite_aw_qos(lite_aw_qos), .lite_aw_region(lite_aw_region), .lite_aw_user(lite_aw_user),
        .lite_aw_valid(lite_aw_valid), .lite_aw_ready(lite_aw_ready),
        .lite_w_data(lite_w_data), .lite_w_strb(lite_w_strb), .lite_w_user(lite_w_user),
        .lite_w_valid(lite_w_valid), .lite_w_ready(lite_w_ready),
        .lite_b_id(lite_b_id), .lite_b_resp(lite_b_resp), .lite_b_user(lite_b_user),
        .lite_b_valid(lite_b_valid), .lite_b_ready(lite_b_ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt)
    );

    typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data; logic [3:0] be;} mw_t;
    typedef struct packed {logic [IDW-1:0] id; logic [1:0] resp; logic [UW-1:0] user;} b_t;
    typedef struct {logic [IDW-1:0] id; logic [AW-1:0] addr; logic [UW-1:0] user;
                    logic [DW-1:0] data; logic [3:0] strb;} pair_t;

    int  n_cmp = 0, n_bad = 0;
    mw_t exp_mw[$], obs_mw[$];
    b_t  exp_b[$], obs_b[$];
    int  gnt_mode = 0;     // 0: gnt tied high, 1: gnt after gnt_delay cycles of req
    int  gnt_delay = 0;
    int  bready_mode = 1;  // 0: low, 1: high, 2: random
    int  stab_viol = 0;

    // Environment: drives gnt/b_ready slightly after negedge and logs handshakes that the next posedge completes.
    int  wait_cnt = 0;
    logic pend = 1'b0;
    mw_t pend_mw, cur_mw;
    always begin
        @(negedge clk);
        #2;
        cur_mw = '{mem_addr, mem_wdata, mem_be};
        if (pend && (!mem_req || cur_mw != pend_mw)) stab_viol++;
        if (gnt_mode == 0) mem_gnt = 1'b1;
        else if (!mem_req) begin wait_cnt = 0; mem_gnt = 1'b0; end
        else begin mem_gnt = (wait_cnt >= gnt_delay); wait_cnt++; end
        if (mem_req && mem_gnt && !rst) obs_mw.push_back(cur_mw);
        pend    = mem_req && !mem_gnt && !rst;
        pend_mw = cur_mw;
        case (bready_mode)
            0:       lite_b_ready = 1'b0;
            1:       lite_b_ready = 1'b1;
            default: lite_b_ready = 1'($urandom_range(0, 1));
        endcase
        if (lite_b_valid && lite_b_ready && !rst) obs_b.push_back('{lite_b_id, lite_b_resp, lite_b_user});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void model(input pair_t p);
        if (int'(p.addr) >= LIMIT) exp_b.push_back('{p.id, 2'b10, p.user});
        else if (p.strb == 4'h0) exp_b.push_back('{p.id, 2'b00, p.user});
        else begin
            exp_mw.push_back('{p.addr & 8'hFC, p.data, p.strb});
            exp_b.push_back('{p.id, 2'b00, p.user});
        end
    endfunction

    function automatic pair_t rand_pair(input bit in_range, input bit allow_zero);
        pair_t p;
        p.id   = IDW'($urandom);
        p.addr = in_range ? AW'($urandom_range(0, LIMIT - 1)) : AW'($urandom_range(0, 255));
        p.user = UW'($urandom);
        p.data = $urandom;
        p.strb = (allow_zero && $urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        return p;
    endfunction

    function automatic void clear_all();
        exp_mw.delete(); obs_mw.delete(); exp_b.delete(); obs_b.delete();
        stab_viol = 0;
    endfunction

    // Drivers: called at a negedge, return at a negedge after the handshake edge.
    task automatic send_aw(input pair_t p, input int gap);
        repeat (gap) @(negedge clk);
        lite_aw_id = p.id; lite_aw_addr = p.addr; lite_aw_user = p.user;
        lite_aw_prot = 3'($urandom); lite_aw_qos = 4'($urandom); lite_aw_valid = 1'b1;
        for (int c = 0; !lite_aw_ready; c++) begin
            if (c >= 300) begin
                n_cmp++; n_bad++;
                $display("FAIL aw_handshake_timeout: aw_ready=%b want 1", lite_aw_ready);
                lite_aw_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk); @(negedge clk);
        lite_aw_valid = 1'b0;
    endtask

    task automatic send_w(input pair_t p, input int gap);
        repeat (gap) @(negedge clk);
        lite_w_data = p.data; lite_w_strb = p.strb; lite_w_user = UW'($urandom); lite_w_valid = 1'b1;
        for (int c = 0; !lite_w_ready; c++) begin
            if (c >= 300) begin
                n_cmp++; n_bad++;
                $display("FAIL w_handshake_timeout: w_ready=%b want 1", lite_w_ready);
                lite_w_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk); @(negedge clk);
        lite_w_valid = 1'b0;
    endtask

    task automatic wait_b(input int n, input int bound, output bit ok);
        int c = 0;
        while (obs_b.size() < n && c < bound) begin @(negedge clk); c++; end
        repeat (3) @(negedge clk);
        ok = (obs_b.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if ({lite_aw_ready, lite_w_ready} !== 2'b11) begin n_bad++; $display("FAIL reset_ready[%0d]: got %b want 11", k, {lite_aw_ready, lite_w_ready}); end
            n_cmp++; if ({lite_b_valid, mem_req} !== 2'b00) begin n_bad++; $display("FAIL reset_valid[%0d]: got %b want 00", k, {lite_b_valid, mem_req}); end
            n_cmp++; if ({mem_addr, mem_wdata, mem_be} !== '0) begin n_bad++; $display("FAIL reset_mem_payload[%0d]: got %h want 0", k, {mem_addr, mem_wdata, mem_be}); end
            n_cmp++; if ({lite_b_id, lite_b_resp, lite_b_user} !== '0) begin n_bad++; $display("FAIL reset_b_payload[%0d]: got %h want 0", k, {lite_b_id, lite_b_resp, lite_b_user}); end
            rst = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_single_write();
        clear_all(); gnt_mode = 0; bready_mode = 1;
        lite_aw_id = 4'd1; lite_aw_addr = 8'h14; lite_aw_user = 2'd1; lite_aw_valid = 1'b1;
        lite_w_data = 32'hDEADBEEF; lite_w_strb = 4'hF; lite_w_valid = 1'b1;
        n_cmp++; if ({lite_aw_ready, lite_w_ready} !== 2'b11) begin n_bad++; $display("FAIL single_ready: got %b want 11", {lite_aw_ready, lite_w_ready}); end
        @(posedge clk); @(negedge clk);
        lite_aw_valid = 1'b0; lite_w_valid = 1'b0;
        n_cmp++; if ({mem_req, lite_b_valid} !== 2'b00) begin n_bad++; $display("FAIL single_cycle1: req/bvalid %b want 00", {mem_req, lite_b_valid}); end
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL single_cycle2_req: got %b want 1", mem_req); end
        n_cmp++; if ({mem_addr, mem_wdata, mem_be} !== {8'h14, 32'hDEADBEEF, 4'hF}) begin n_bad++; $display("FAIL single_payload: got %h %h %h want 14 deadbeef f", mem_addr, mem_wdata, mem_be); end
        @(negedge clk);
        n_cmp++; if ({lite_b_valid, lite_b_id, lite_b_resp, lite_b_user, mem_req} !== {1'b1, 4'd1, 2'b00, 2'd1, 1'b0}) begin n_bad++;
            $display("FAIL single_b: valid=%b id=%0d resp=%0d user=%0d req=%b want 1 1 0 1 0", lite_b_valid, lite_b_id, lite_b_resp, lite_b_user, mem_req); end
        repeat (2) @(negedge clk);
    endtask

    // Drive one pair at once and check B at cycle 2 (no-memory paths) or mem_addr at cycle 2.
    task automatic test_edge_cases();
        pair_t p[3];
        logic [1:0] want_resp[3];
        p[0] = '{4'd5, 8'h80, 2'd2, 32'h12345678, 4'hF}; want_resp[0] = 2'b10;
        p[1] = '{4'd3, 8'h20, 2'd1, 32'hCAFEF00D, 4'h0}; want_resp[1] = 2'b00;
        p[2] = '{4'd9, 8'hFF, 2'd3, 32'h0BADF00D, 4'h3}; want_resp[2] = 2'b10;
        gnt_mode = 0; bready_mode = 1;
        for (int i = 0; i < 3; i++) begin
            clear_all();
            fork send_aw(p[i], 0); send_w(p[i], 0); join
            n_cmp++; if (lite_b_valid !== 1'b0) begin n_bad++; $display("FAIL edge%0d_cycle1_bvalid: got %b want 0", i, lite_b_valid); end
            @(negedge clk);
            n_cmp++; if ({lite_b_valid, lite_b_id, lite_b_resp, lite_b_user} !== {1'b1, p[i].id, want_resp[i], p[i].user}) begin n_bad++;
                $display("FAIL edge%0d_b: valid=%b id=%0d resp=%0d user=%0d want 1 %0d %0d %0d", i, lite_b_valid, lite_b_id, lite_b_resp, lite_b_user, p[i].id, want_resp[i], p[i].user); end
            repeat (3) @(negedge clk);
            n_cmp++; if (obs_mw.size() != 0) begin n_bad++; $display("FAIL edge%0d_no_mem: got %0d writes want 0", i, obs_mw.size()); end
        end
        clear_all();
        p[0] = '{4'd7, 8'h17, 2'd0, 32'h55AA33CC, 4'h6};
        fork send_aw(p[0], 0); send_w(p[0], 0); join
        @(negedge clk);
        n_cmp++; if ({mem_req, mem_addr, mem_be} !== {1'b1, 8'h14, 4'h6}) begin n_bad++; $display("FAIL edge_unaligned: req=%b addr=%h be=%h want 1 14 6", mem_req, mem_addr, mem_be); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_skew_backpressure();
        pair_t v[3];
        bit ok;
        clear_all(); gnt_mode = 1; gnt_delay = 4; bready_mode = 1;
        for (int i = 0; i < 3; i++) begin v[i] = rand_pair(1, 0); model(v[i]); end
        send_aw(v[0], 0); send_aw(v[1], 0);
        repeat (2) @(negedge clk);
        n_cmp++; if ({lite_aw_ready, lite_w_ready} !== 2'b01) begin n_bad++; $display("FAIL skew_aw_full: aw/w ready %b want 01", {lite_aw_ready, lite_w_ready}); end
        fork
            send_aw(v[2], 0);
            begin for (int i = 0; i < 3; i++) send_w(v[i], 0); end
        join
        wait_b(3, 300, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL skew_b_count: got %0d want 3", obs_b.size()); end
        n_cmp++; if (obs_mw.size() != exp_mw.size()) begin n_bad++; $display("FAIL skew_mw_count: got %0d want %0d", obs_mw.size(), exp_mw.size()); end
        for (int i = 0; i < exp_mw.size() && i < obs_mw.size(); i++) begin
            n_cmp++; if (obs_mw[i] !== exp_mw[i]) begin n_bad++; $display("FAIL skew_mw[%0d]: got %h want %h", i, obs_mw[i], exp_mw[i]); end
        end
        n_cmp++; if (stab_viol != 0) begin n_bad++; $display("FAIL skew_req_stable: got %0d changes want 0", stab_viol); end
    endtask

    task automatic test_b_stall();
        pair_t v[4];
        bit ok;
        clear_all(); gnt_mode = 0; bready_mode = 0;
        for (int i = 0; i < 4; i++) begin v[i] = rand_pair(1, 0); model(v[i]); end
        fork
            begin for (int i = 0; i < 4; i++) send_aw(v[i], 0); end
            begin for (int i = 0; i < 4; i++) send_w(v[i], 0); end
        join
        repeat (8) @(negedge clk);
        n_cmp++; if (obs_mw.size() != 2) begin n_bad++; $display("FAIL stall_mw_count: got %0d want 2", obs_mw.size()); end
        n_cmp++; if ({lite_aw_ready, lite_w_ready, lite_b_valid} !== 3'b001) begin n_bad++; $display("FAIL stall_flags: aw/w ready, bvalid %b want 001", {lite_aw_ready, lite_w_ready, lite_b_valid}); end
        bready_mode = 1;
        wait_b(4, 100, ok);
        n_cmp++; if (!ok || obs_b.size() != 4) begin n_bad++; $display("FAIL stall_b_count: got %0d want 4", obs_b.size()); end
        for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
            n_cmp++; if (obs_b[i] !== exp_b[i]) begin n_bad++; $display("FAIL stall_b[%0d]: got %h want %h", i, obs_b[i], exp_b[i]); end
        end
        for (int i = 0; i < exp_mw.size() && i < obs_mw.size(); i++) begin
            n_cmp++; if (obs_mw[i] !== exp_mw[i]) begin n_bad++; $display("FAIL stall_mw[%0d]: got %h want %h", i, obs_mw[i], exp_mw[i]); end
        end
    endtask

    task automatic test_reset_midop();
        pair_t p;
        clear_all(); gnt_mode = 1; gnt_delay = 1000; bready_mode = 1;
        p = rand_pair(1, 0);
        fork send_aw(p, 0); send_w(p, 0); join
        for (int c = 0; c < 20 && !mem_req; c++) @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL midop_req_pending: got %b want 1", mem_req); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({mem_req, lite_b_valid} !== 2'b00) begin n_bad++; $display("FAIL midop_drop: req/bvalid %b want 00", {mem_req, lite_b_valid}); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if ({lite_aw_ready, lite_w_ready, mem_req, lite_b_valid} !== 4'b1100) begin n_bad++; $display("FAIL midop_after: aw/w ready req bvalid %b want 1100", {lite_aw_ready, lite_w_ready, mem_req, lite_b_valid}); end
        repeat (5) @(negedge clk);
        n_cmp++; if (obs_b.size() + obs_mw.size() != 0) begin n_bad++; $display("FAIL midop_no_b: got %0d B, %0d writes want 0", obs_b.size(), obs_mw.size()); end
    endtask

    task automatic test_random();
        pair_t v[$];
        bit ok;
        clear_all(); gnt_mode = 1; gnt_delay = $urandom_range(0, 3); bready_mode = 2;
        for (int i = 0; i < 24; i++) begin v.push_back(rand_pair(0, 1)); model(v[i]); end
        fork
            begin for (int i = 0; i < 24; i++) send_aw(v[i], $urandom_range(0, 2)); end
            begin for (int i = 0; i < 24; i++) send_w(v[i], $urandom_range(0, 3)); end
        join
        wait_b(24, 1000, ok);
        n_cmp++; if (!ok || obs_b.size() != 24) begin n_bad++; $display("FAIL random_b_count: got %0d want 24", obs_b.size()); end
        n_cmp++; if (obs_mw.size() != exp_mw.size()) begin n_bad++; $display("FAIL random_mw_count: got %0d want %0d", obs_mw.size(), exp_mw.size()); end
        for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
            n_cmp++; if (obs_b[i] !== exp_b[i]) begin n_bad++; $display("FAIL random_b[%0d]: got %h want %h", i, obs_b[i], exp_b[i]); end
        end
        for (int i = 0; i < exp_mw.size() && i < obs_mw.size(); i++) begin
            n_cmp++; if (obs_mw[i] !== exp_mw[i]) begin n_bad++; $display("FAIL random_mw[%0d]: got %h want %h", i, obs_mw[i], exp_mw[i]); end
        end
        n_cmp++; if (stab_viol != 0) begin n_bad++; $display("FAIL random_req_stable: got %0d changes want 0", stab_viol); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_edge_cases();
        test_skew_backpressure();
        test_b_stall();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/nasti_lite_mem_writer.md
# nasti_lite_mem_writer

Downstream NASTI-lite write slave: consumes the single-beat lite AW/W stream that the NASTI-to-lite write converter produces and turns each pair into one word write on a simple req/gnt memory port. It returns one B response per write, in order, carrying the AW id and user. Writes outside the implemented address window are answered with SLVERR and never reach memory.

## Interface
- ID_WIDTH, 1, id width
- ADDR_WIDTH, 8, byte address width
- DATA_WIDTH, 32, lite data width; only 32 or 64 are legal, otherwise `$fatal` at elaboration
- USER_WIDTH, 1, user field width, must be > 0
- FIFO_DEPTH, 2, entries in each of the AW, W and B FIFOs; power of two, >= 2
- ADDR_LIMIT, 2**ADDR_WIDTH, first out-of-range byte address

Ports:
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- lite_aw_id/addr/prot/qos/region/user  in  ID/ADDR/3/4/4/USER  write address; prot/qos/region accepted and ignored
- lite_aw_valid  in  1 ; lite_aw_ready  out  1
- lite_w_data/strb/user  in  DATA/DATA/8/USER  write data; w_user ignored
- lite_w_valid  in  1 ; lite_w_ready  out  1
- lite_b_id/resp/user  out  ID/2/USER  response
- lite_b_valid  out  1 ; lite_b_ready  in  1
- mem_req  out  1  write request, held until granted
- mem_addr  out  ADDR_WIDTH  word-aligned byte address
- mem_wdata  out  DATA_WIDTH ; mem_be  out  DATA_WIDTH/8  byte enables
- mem_gnt  in  1  write accepted in the cycle where mem_req && mem_gnt

## Operation
- **AW FIFO**: stores id, addr and user. lite_aw_ready = !full. A push happens on valid && ready. There is no bypass: a full FIFO deasserts ready even in a cycle where it pops.
- **W FIFO**: stores data and strb. Same ready/push rules as the AW FIFO.
- **B FIFO**: stores id, resp and user. lite_b_valid = !empty. An entry pops on lite_b_valid && lite_b_ready.
- **Issue FSM, IDLE**: when the AW and W FIFOs are both non-empty and the B FIFO is not full, pop both heads in the same cycle. AW is never paired with a later W out of order.
  - addr >= ADDR_LIMIT: push B {id, SLVERR=2'b10, user} in the same cycle; stay IDLE.
  - strb == 0: push B {id, OKAY, user} in the same cycle with no memory access; stay IDLE.
  - Otherwise: load the issue register (id, user, addr with its low log2(DATA_WIDTH/8) bits cleared, data, strb) and go to REQ.
- **Issue FSM, REQ**: mem_req = 1 with stable addr/wdata/be. On mem_gnt, push B {id, OKAY=2'b00, user} and return to IDLE. The B slot needs no reservation because only one write is in flight and the B FIFO can only drain during REQ.
- Unaligned addresses: the low bits are silently dropped; strb is passed through unchanged.
- Ordering: B order equals AW order, whatever the ids are.

## Timing
- **While rst = 1 and in the first cycle after it**:
  - lite_aw_ready = lite_w_ready = 1 (both FIFOs empty).
  - lite_b_valid = 0, mem_req = 0.
  - mem_addr/wdata/be = 0, lite_b_id/resp/user = 0.
  - FSM = IDLE, all FIFO pointers and counts = 0.
- **Reset mid-operation**: all FIFOs flush, an outstanding mem_req drops in the next cycle, and no B is produced for the lost writes.
- **Latency**: AW and W handshaken in cycle 0 → heads visible and popped in cycle 1 → mem_req = 1 in cycle 2 → with gnt in cycle 2, lite_b_valid = 1 in cycle 3. Minimum is 3 cycles from handshake to B valid.
- **Error/no-strobe path**: B valid 2 cycles after the handshake.
- **Throughput**: one memory write per 2 cycles with gnt tied high (IDLE/REQ alternate). Error writes sustain one per cycle.
- **AW/W skew**: either channel may lead by up to FIFO_DEPTH beats; the leading channel stalls once its FIFO is full.
- **mem_req protocol**: once raised, mem_req and its payload must not change until mem_gnt.
- **B backpressure**: a full B FIFO stalls IDLE, and then AW/W ready drops as those FIFOs fill.
- **Pointers**: wrap modulo FIFO_DEPTH. Counts are log2(FIFO_DEPTH)+1 bits wide, so full and empty are unambiguous.

## Test plan
- **Single write**: AW id=1 addr=0x14, W data=0xDEADBEEF strb=0xF, gnt tied 1 → mem_req in cycle 2 with mem_addr=0x14, wdata=0xDEADBEEF, be=0xF; B id=1 resp=0 in cycle 3.
- **Out of range** (ADDR_LIMIT=0x80): AW addr=0x80 → no mem_req; B resp=2'b10 with matching id/user.
- **Skew and backpressure**: 3 AW beats with W held off and FIFO_DEPTH=2 → aw_ready drops after 2 beats. Then release W with gnt delayed 4 cycles per write → 3 mem writes in order, mem_req stable while waiting.
- **B stall**: lite_b_ready=0 while issuing 4 writes (depth 2) → exactly 2 mem writes, then w_ready/aw_ready deassert. Raising b_ready drains all 4 B beats in order.
- **Edge cases**: strb=0 → OKAY with no mem_req. addr=0x17 with DATA_WIDTH=32 → mem_addr=0x14.
- **Reset mid-op**: rst asserted while mem_req is pending → mem_req=0 and b_valid=0 the next cycle, both readies = 1 after reset.
